fpdiv_round_pack: RTL

- Downstream stage of the single-precision divider.
- Consumes the raw quotient, sign, unnormalised biased exponent and special-case class produced by the mantissa divide step.
- Normalises the quotient, rounds to nearest-even, applies overflow/underflow/special-case substitution and emits a packed IEEE-754 binary32 result plus exception flags.
- Two-stage registered pipeline with valid/ready handshakes on both sides; full throughput.

---
 rtl/fpdiv_pkg.sv | 36 +++
 rtl/fpdiv_rne_round.sv | 22 ++
 rtl/fpdiv_round_pack.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the binary32 divider back end.
package fpdiv_pkg;

  // Operand class produced by the mantissa divide step.
  typedef enum logic [2:0] {
    FP_NORM = 3'd0,
    FP_ZERO = 3'd1,
    FP_INF  = 3'd2,
    FP_NAN  = 3'd3,
    FP_DZ   = 3'd4
  } fp_class_e;

  // Bit positions inside the 5-bit exception flag vector {NV, DZ, OF, UF, NX}.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 2 * BIAS + 1;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Unused encodings (5-7) collapse onto the invalid class.
  function automatic fp_class_e decode_class(input logic [2:0] raw);
    case (raw)
      3'd0:    return FP_NORM;
      3'd1:    return FP_ZERO;
      3'd2:    return FP_INF;
      3'd3:    return FP_NAN;
      3'd4:    return FP_DZ;
      default: return FP_NAN;
    endcase
  endfunction

endpackage

// File: rtl/fpdiv_rne_round.sv
// Round-to-nearest-even on a 24-bit significand with guard and sticky bits.
module fpdiv_rne_round (
  input  logic [23:0] mant,
  input  logic        guard,
  input  logic        sticky,
  output logic [23:0] mant_rnd,
  output logic        carry,
  output logic        inexact
);

  logic        inc;
  logic [24:0] sum;

  // Round up above the halfway point, or exactly at it when the lsb is odd.
  assign inc      = guard & (sticky | mant[0]);
  assign sum      = {1'b0, mant} + {24'b0, inc};
  assign carry    = sum[24];
  // A carry out means 1.111..1 rounded to 10.000..0; renormalise to 1.0.
  assign mant_rnd = carry ? 24'h80_0000 : sum[23:0];
  assign inexact  = guard | sticky;

endmodule

// File: rtl/fpdiv_round_pack.sv
// Divider back end: normalise (stage 1), round and pack (stage 2).
module fpdiv_round_pack
  import fpdiv_pkg::*;
#(
  parameter int QW    = 27,
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [QW-1:0]    in_quot,
  input  logic             in_sticky,
  input  logic [2:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags
);

  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_TOP  = EXP_W'(EXP_MAX);

  // Stage 1 state
  logic                    s1_valid;
  logic                    s1_sign;
  logic signed [EXP_W-1:0] s1_exp;
  logic [23:0]             s1_mant;
  logic                    s1_guard;
  logic                    s1_sticky;
  fp_class_e               s1_class;

  logic s1_adv;

  // Stage 2 is the output register itself, so its valid is out_valid.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  // One zero appended below the lsb so the shifted path still has a
  // (possibly empty) sticky field when QW is at its minimum of 26.
  logic [QW:0]             quot_ext;
  logic signed [EXP_W-1:0] exp_in_s;
  logic [23:0]             norm_mant;
  logic                    norm_guard;
  logic                    norm_sticky;
  logic signed [EXP_W-1:0] norm_exp;

  assign quot_ext = {in_quot, 1'b0};
  assign exp_in_s = in_exp;

  // Normalise: quotients below 1.0 shift left by one and borrow from the exponent.
  always_comb begin
    norm_mant   = quot_ext[QW:QW-23];
    norm_guard  = quot_ext[QW-24];
    norm_sticky = (|quot_ext[QW-25:0]) | in_sticky;
    norm_exp    = exp_in_s;
    if (!quot_ext[QW]) begin
      norm_mant   = quot_ext[QW-1:QW-24];
      norm_guard  = quot_ext[QW-25];
      norm_sticky = (|quot_ext[QW-26:0]) | in_sticky;
      norm_exp    = exp_in_s - EXP_ONE;
    end
  end

  // Stage 1 register: capture the normalised operand when the stage can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_mant   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_class  <= FP_NORM;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= in_sign;
        s1_exp    <= norm_exp;
        s1_mant   <= norm_mant;
        s1_guard  <= norm_guard;
        s1_sticky <= norm_sticky;
        s1_class  <= decode_class(in_class);
      end
    end
  end

  logic [23:0]             rnd_mant;
  logic                    rnd_carry;
  logic                    rnd_inexact;
  logic signed [EXP_W-1:0] exp_rnd;

  fpdiv_rne_round u_rne (
    .mant     (s1_mant),
    .guard    (s1_guard),
    .sticky   (s1_sticky),
    .mant_rnd (rnd_mant),
    .carry    (rnd_carry),
    .inexact  (rnd_inexact)
  );

  assign exp_rnd = s1_exp + (rnd_carry ? EXP_ONE : EXP_ZERO);

  logic [31:0] result_next;
  logic [4:0]  flags_next;

  // Pack: special classes bypass rounding, normals get range checks.
  always_comb begin
    result_next = '0;
    flags_next  = '0;
    case (s1_class)
      FP_ZERO: begin
        result_next = {s1_sign, 31'b0};
      end
      FP_INF: begin
        result_next = {s1_sign, 8'hFF, 23'b0};
      end
      FP_DZ: begin
        result_next         = {s1_sign, 8'hFF, 23'b0};
        flags_next[FLAG_DZ] = 1'b1;
      end
      FP_NORM: begin
        if (!rnd_mant[23]) begin
          // No hidden bit means the upstream quotient was unnormalised;
          // there is no meaningful value to pack, so report invalid.
          result_next         = QNAN;
          flags_next[FLAG_NV] = 1'b1;
        end else if (exp_rnd >= EXP_TOP) begin
          result_next         = {s1_sign, 8'hFF, 23'b0};
          flags_next[FLAG_OF] = 1'b1;
          flags_next[FLAG_NX] = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
          // Subnormals are not produced; tiny results flush to signed zero.
          result_next         = {s1_sign, 31'b0};
          flags_next[FLAG_UF] = 1'b1;
          flags_next[FLAG_NX] = 1'b1;
        end else begin
          result_next         = {s1_sign, exp_rnd[7:0], rnd_mant[22:0]};
          flags_next[FLAG_NX] = rnd_inexact;
        end
      end
      default: begin
        result_next         = QNAN;
        flags_next[FLAG_NV] = 1'b1;
      end
    endcase
  end

  // Stage 2 register: outputs hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result_next;
        out_flags  <= flags_next;
      end
    end
  end

endmodule
